std_sram_64d128x_reqctl: RTL

- Request/response front-end for the 64-deep, 128-bit, bit-write-enable single-port SRAM macro wrapper (active-high en/we/bwe, 1-clk read latency).
- Converts a valid/ready request channel into SRAM port cycles.
- Buffers read data in a response FIFO so downstream backpressure never loses data.
- Zero-initialises the whole array after reset before accepting traffic.

---
 rtl/std_sram_64d128x_reqctl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/std_sram_64d128x_reqctl.sv
// Request/response front-end for the 64 x 128 bit-write-enable single-port SRAM.
// Turns a valid/ready request channel into SRAM port cycles, buffers read data in
// a response FIFO sized by read credits, and zero-fills the array after reset.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req_valid / o_req_ready  request handshake (fire = valid && ready)
//   i_req_addr/we/bwe/din      request payload (bwe/din used by writes only)
//   o_resp_valid / i_resp_ready / o_resp_data   read response channel (FIFO head)
//   o_init_done                high once the zero-fill sweep has completed
//   o_sram_en/we/addr/bwe/din  SRAM macro port drive
//   i_sram_dout                SRAM read data, valid one cycle after a read
module std_sram_64d128x_reqctl #(
  parameter bit          INIT_EN    = 1'b1,
  parameter int unsigned RESP_DEPTH = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic [5:0]   i_req_addr,
  input  logic         i_req_we,
  input  logic [127:0] i_req_bwe,
  input  logic [127:0] i_req_din,
  output logic         o_resp_valid,
  input  logic         i_resp_ready,
  output logic [127:0] o_resp_data,
  output logic         o_init_done,
  output logic         o_sram_en,
  output logic         o_sram_we,
  output logic [5:0]   o_sram_addr,
  output logic [127:0] o_sram_bwe,
  output logic [127:0] o_sram_din,
  input  logic [127:0] i_sram_dout
);

  localparam int unsigned AW      = 6;
  localparam int unsigned DW      = 128;
  localparam int unsigned ENTRIES = 64;
  localparam int unsigned PTR_W   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned OCC_W   = $clog2(RESP_DEPTH + 1);
  localparam int unsigned SUM_W   = OCC_W + 1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [0:0] ST_RESET = INIT_EN ? ST_INIT : ST_RUN;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic          init_done_q, init_done_d;
  logic          inflight_q, inflight_d;

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]    fifo_mem_q [RESP_DEPTH];

  logic          credit_c;
  logic          req_ready_c;
  logic          fire_c;
  logic          push_c;
  logic          pop_c;
  logic          sram_en_c;
  logic          sram_we_c;
  logic [AW-1:0] sram_addr_c;
  logic [DW-1:0] sram_bwe_c;
  logic [DW-1:0] sram_din_c;

  // Modulo-RESP_DEPTH increment, correct for non-power-of-2 depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A read may only issue if its data is guaranteed a FIFO slot; only registered terms.
  assign credit_c = (SUM_W'(occ_q) + SUM_W'(inflight_q)) < SUM_W'(RESP_DEPTH);
  assign fire_c   = i_req_valid & req_ready_c;

  // Next-state and SRAM drive; idle cycles still drive request fields for stability.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    req_ready_c = 1'b0;
    sram_en_c   = 1'b0;
    sram_we_c   = i_req_we;
    sram_addr_c = i_req_addr;
    sram_bwe_c  = i_req_bwe;
    sram_din_c  = i_req_din;
    case (state_q)
      ST_INIT: begin
        sram_en_c   = ~reset;
        sram_we_c   = 1'b1;
        sram_addr_c = init_cnt_q;
        sram_bwe_c  = '1;
        sram_din_c  = '0;
        init_cnt_d  = init_cnt_q + AW'(1);
        if (init_cnt_q == AW'(ENTRIES - 1)) state_d = ST_RUN;
      end
      default: begin
        req_ready_c = ~reset & (i_req_we | credit_c);
        sram_en_c   = i_req_valid & req_ready_c;
      end
    endcase
  end

  assign init_done_d = (state_d == ST_RUN);
  assign inflight_d  = fire_c & ~i_req_we;

  // Read data lands one cycle after the fire; pop on handshake, both may coincide.
  always_comb begin
    push_c   = inflight_q;
    pop_c    = (occ_q != '0) & i_resp_ready;
    wr_ptr_d = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RESET;
      init_cnt_q  <= '0;
      init_done_q <= ~INIT_EN;
      inflight_q  <= 1'b0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Response storage; contents are meaningless while occupancy says empty.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem_q[wr_ptr_q] <= i_sram_dout;
  end

  assign o_req_ready  = req_ready_c;
  assign o_resp_valid = (occ_q != '0);
  assign o_resp_data  = fifo_mem_q[rd_ptr_q];
  assign o_init_done  = init_done_q;
  assign o_sram_en    = sram_en_c;
  assign o_sram_we    = sram_we_c;
  assign o_sram_addr  = sram_addr_c;
  assign o_sram_bwe   = sram_bwe_c;
  assign o_sram_din   = sram_din_c;

  // Credit scheme must keep the FIFO from overflowing.
  a_occ_bound : assert property (@(posedge clk) disable iff (reset)
                                 occ_q <= OCC_W'(RESP_DEPTH));

endmodule
